// File: rtl/uart_tx_framer_if.sv
// Byte handshake between the system-side source and the UART framer.
// The source drives send/din; the framer answers with busy.
interface uart_tx_framer_if;
    logic       send;
    logic [7:0] din;
    logic       busy;

    modport master (
        output send,
        output din,
        input  busy
    );

    modport slave (
        input  send,
        input  din,
        output busy
    );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, 8 data bits LSB first,
// optional odd parity, stop, then wait for send to drop.
module uart_tx_framer #(
    parameter int BAUD_DIV  = 868,
    parameter int PARITY_EN = 1,
    parameter int DATA_BITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_framer_if.slave   bus,
    output logic              tx_out,
    output logic              tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        ACK
    } state_e;

    localparam logic [15:0] LAST_TICK = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  LAST_IDX  = 3'(DATA_BITS - 1);

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        bit_done;

    assign bit_done = (timer_q == LAST_TICK);
    assign tx_out   = tx_q;
    assign bus.busy = busy_q;

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: frame sequencing and baud timing.
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        idx_d   = idx_q;
        data_d  = data_q;
        par_d   = par_q;
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (bus.send) begin
                    state_d = START;
                    data_d  = bus.din;
                    par_d   = ~^bus.din;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
            STOP: begin
                if (bit_done) state_d = ACK;
            end
            ACK: begin
                if (!bus.send) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_q inside {START, DATA, PARITY, STOP}) begin
            timer_d = bit_done ? '0 : timer_q + 16'd1;
        end
    end

    // Outputs: line level for the upcoming state, done strobe.
    always_comb begin
        tx_d    = 1'b1;
        busy_d  = (state_d != IDLE);
        tx_done = (state_q == STOP) && bit_done;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[idx_d];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: two instances (parity on/off)
// checked per cycle against a frame-level model.
module tb_uart_tx_framer;

    localparam int B = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       send;
    logic [7:0] din;
    logic       txp, donep, txn, donen;

    always #5 clk = ~clk;

    uart_tx_framer_if bp ();
    uart_tx_framer_if bn ();

    assign bp.send = send;
    assign bp.din  = din;
    assign bn.send = send;
    assign bn.din  = din;

    uart_tx_framer #(.BAUD_DIV(B), .PARITY_EN(1)) dut_p (
        .clk(clk), .reset(reset), .bus(bp),
        .tx_out(txp), .tx_done(donep)
    );

    uart_tx_framer #(.BAUD_DIV(B), .PARITY_EN(0)) dut_n (
        .clk(clk), .reset(reset), .bus(bn),
        .tx_out(txn), .tx_done(donen)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame-level model: mode 0 idle, 1 in frame, 2 awaiting send low.
    int mode [2];
    int cnt  [2];
    int nb   [2];
    bit fb   [2][11];
    int pe   [2];

    initial begin
        pe[0] = 1;
        pe[1] = 0;
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0;
            cnt[i]  = 0;
            nb[i]   = 10 + pe[i];
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (reset === 1'b1) begin
                    mode[i] = 0;
                end else if (mode[i] == 0) begin
                    if (send === 1'b1) begin
                        int ones;
                        ones = 0;
                        fb[i][0] = 1'b0;
                        for (int b = 0; b < 8; b++) begin
                            fb[i][1 + b] = din[b];
                            ones += int'(din[b]);
                        end
                        if (pe[i] != 0) fb[i][9] = (ones % 2 == 0);
                        fb[i][nb[i] - 1] = 1'b1;
                        mode[i] = 1;
                        cnt[i]  = 0;
                    end
                end else if (mode[i] == 1) begin
                    if (cnt[i] == nb[i] * B - 1) mode[i] = 2;
                    else cnt[i]++;
                end else begin
                    if (send === 1'b0) mode[i] = 0;
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                logic e_tx, e_busy, e_done;
                logic a_tx, a_busy, a_done;
                e_tx   = (mode[i] == 1) ? fb[i][cnt[i] / B] : 1'b1;
                e_busy = (mode[i] != 0);
                e_done = (mode[i] == 1) && (cnt[i] == nb[i] * B - 1);
                a_tx   = (i == 0) ? txp : txn;
                a_busy = (i == 0) ? bp.busy : bn.busy;
                a_done = (i == 0) ? donep : donen;
                chk($sformatf("model tx[%0d]", i), 32'(a_tx), 32'(e_tx));
                chk($sformatf("model busy[%0d]", i), 32'(a_busy), 32'(e_busy));
                chk($sformatf("model done[%0d]", i), 32'(a_done), 32'(e_done));
            end
        end
    end

    logic tp [48];
    logic tn [48];
    logic dp [48];
    logic dn [48];
    logic bsp[48];
    logic bsn[48];

    task automatic run_frame(input logic [7:0] d, input int chg_j,
                             input logic [7:0] chg_v, input int rst_j);
        @(negedge clk);
        send = 1'b1;
        din  = d;
        @(negedge clk);
        send = 1'b0;
        for (int j = 0; j < 48; j++) begin
            tp[j]  = txp;
            tn[j]  = txn;
            dp[j]  = donep;
            dn[j]  = donen;
            bsp[j] = bp.busy;
            bsn[j] = bn.busy;
            if (j == chg_j) din = chg_v;
            reset = (j == rst_j);
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    task automatic chk_bits(string name, bit exp[11], int n, int use_p);
        for (int k = 0; k < n; k++) begin
            logic a;
            a = use_p ? tp[4 * k + 1] : tn[4 * k + 1];
            chk($sformatf("%s bit%0d", name, k), 32'(a), 32'(exp[k]));
        end
    endtask

    function automatic int count(logic v[48], int lo, int hi);
        int c;
        c = 0;
        for (int j = lo; j <= hi; j++) c += int'(v[j] === 1'b1);
        return c;
    endfunction

    bit e55[11] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
    bit e07[11] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    bit eA3[11] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0};
    bit e3C[11] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};

    initial begin
        int pulses_p, pulses_n;
        reset = 1'b1;
        send  = 1'b0;
        din   = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset tx", 32'(txp), 32'd1);
        chk("reset busy", 32'(bp.busy), 32'd0);
        chk("reset done", 32'(donep), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_frame(8'h55, -1, 8'h00, -1);
        chk_bits("p55", e55, 11, 1);
        chk("p55 done at 44", 32'(dp[43]), 32'd1);
        chk("p55 done once", 32'(count(dp, 0, 47)), 32'd1);
        chk("p55 busy 44", 32'(count(bsp, 0, 43)), 32'd44);
        chk("p55 stop done", 32'(tp[43]), 32'd1);

        run_frame(8'h07, -1, 8'h00, -1);
        chk_bits("p07", e07, 11, 1);
        chk("p07 done at 44", 32'(dp[43]), 32'd1);
        chk("p07 done once", 32'(count(dp, 0, 47)), 32'd1);

        run_frame(8'hA3, -1, 8'h00, -1);
        chk_bits("nA3", eA3, 10, 0);
        chk("nA3 done at 40", 32'(dn[39]), 32'd1);
        chk("nA3 done once", 32'(count(dn, 0, 47)), 32'd1);
        chk("nA3 ack busy", 32'(bsn[40]), 32'd1);
        chk("nA3 idle", 32'(bsn[41]), 32'd0);

        run_frame(8'h55, 10, 8'hFF, -1);
        chk_bits("p55chg", e55, 11, 1);

        run_frame(8'h55, -1, 8'h00, 17);
        chk("rst tx", 32'(tp[18]), 32'd1);
        chk("rst busy", 32'(bsp[18]), 32'd0);
        chk("rst done", 32'(dp[18]), 32'd0);
        chk("rst busy n", 32'(bsn[18]), 32'd0);
        run_frame(8'h3C, -1, 8'h00, -1);
        chk_bits("p3C", e3C, 11, 1);
        chk("p3C done once", 32'(count(dp, 0, 47)), 32'd1);

        @(negedge clk);
        send     = 1'b1;
        din      = 8'($urandom);
        pulses_p = 0;
        pulses_n = 0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            pulses_p += int'(donep);
            pulses_n += int'(donen);
        end
        chk("hold pulses p", 32'(pulses_p), 32'd1);
        chk("hold pulses n", 32'(pulses_n), 32'd1);
        chk("hold busy", 32'(bp.busy), 32'd1);
        send = 1'b0;
        @(negedge clk);
        chk("drop busy", 32'(bp.busy), 32'd0);
        send = 1'b1;
        @(negedge clk);
        chk("resend busy", 32'(bp.busy), 32'd1);
        chk("resend tx", 32'(txp), 32'd0);
        send = 1'b0;
        repeat (50) @(negedge clk);

        for (int j = 0; j < 3000; j++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) send = ~send;
            din = 8'($urandom);
            @(negedge clk);
        end
        reset = 1'b0;
        send  = 1'b0;
        repeat (60) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
